// File: rtl/zap_ram_arb_pkg.sv
// Shared types, constants and the 2-way pick helper for zap_ram_arbiter.
// Optional build macro: ZAP_RAM_ARB_RR_EN (round-robin arbitration).
package zap_ram_arb_pkg;

  // Clock-enabled cycles between read issue and RAM data
  localparam int ZAP_RAM_ARB_RD_LAT = 3;

  // One read in flight: valid flag plus the port the data belongs to
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  // Grant one of two requesters, preferring the port named by favour
  function automatic logic [1:0] pick_grant(input logic [1:0] req, input logic favour);
    logic [1:0] grant;
    grant = 2'b00;
    if (favour) begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end else begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
    return grant;
  endfunction

endpackage

// File: rtl/zap_ram_arb_pick.sv
// Two-way picker for one request class (writes or reads).
// ZAP_RAM_ARB_RR_EN defined: 1-bit round-robin pointer that moves only on grant.
// ZAP_RAM_ARB_RR_EN undefined: fixed priority to port 0, no state at all.
module zap_ram_arb_pick
  import zap_ram_arb_pkg::*;
(
`ifdef ZAP_RAM_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef ZAP_RAM_ARB_RR_EN
  logic favour;

  // Grant the favoured port if it asks, otherwise the other one
  always_comb begin
    grant = 2'b00;
    if (enable) grant = pick_grant(req, favour);
  end

  // After a grant, favour the port that did not just win
  always_ff @(posedge clk) begin
    if (reset)       favour <= 1'b0;
    else if (|grant) favour <= grant[0];
  end
`else
  // Port 0 always wins when it asks
  always_comb begin
    grant = 2'b00;
    if (enable) grant = pick_grant(req, 1'b0);
  end
`endif

endmodule

// File: rtl/zap_ram_arbiter.sv
// Two-port access controller for the 3-cycle pipelined simple RAM.
// Issues at most one write and one read per cycle, tracks reads with a tag
// pipeline and stalls the RAM through its clock enable on response backpressure.
// Optional build macro: ZAP_RAM_ARB_RR_EN (round-robin instead of port-0 priority).
module zap_ram_arbiter
  import zap_ram_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0_valid,
  input  logic             i_req0_wr,
  input  logic [AW-1:0]    i_req0_addr,
  input  logic [WIDTH-1:0] i_req0_wdata,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic             i_req1_wr,
  input  logic [AW-1:0]    i_req1_addr,
  input  logic [WIDTH-1:0] i_req1_wdata,
  output logic             o_req1_ready,
  output logic             o_rsp0_valid,
  output logic [WIDTH-1:0] o_rsp0_data,
  input  logic             i_rsp0_ready,
  output logic             o_rsp1_valid,
  output logic [WIDTH-1:0] o_rsp1_data,
  input  logic             i_rsp1_ready,
  output logic             o_ram_clken,
  output logic             o_ram_wr_en,
  output logic [AW-1:0]    o_ram_wr_addr,
  output logic [WIDTH-1:0] o_ram_wr_data,
  output logic [AW-1:0]    o_ram_rd_addr,
  input  logic [WIDTH-1:0] i_ram_rd_data
);

  tag_t       tag_pipe [ZAP_RAM_ARB_RD_LAT];
  tag_t       tag_out;
  logic       stall;
  logic       advance;
  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic [1:0] wr_grant;
  logic [1:0] rd_grant;

  assign tag_out = tag_pipe[ZAP_RAM_ARB_RD_LAT-1];

  // Freeze the RAM while the port owning the oldest read refuses its data
  always_comb begin
    stall = 1'b0;
    if (tag_out.valid && !i_reset) stall = tag_out.port ? ~i_rsp1_ready : ~i_rsp0_ready;
  end

  assign o_ram_clken = ~stall;
  assign advance     = ~stall & ~i_reset;
  assign wr_req      = {i_req1_valid & i_req1_wr,  i_req0_valid & i_req0_wr};
  assign rd_req      = {i_req1_valid & ~i_req1_wr, i_req0_valid & ~i_req0_wr};

  zap_ram_arb_pick u_wr_pick (
`ifdef ZAP_RAM_ARB_RR_EN
    .clk    (i_clk),
    .reset  (i_reset),
`endif
    .enable (advance),
    .req    (wr_req),
    .grant  (wr_grant)
  );

  zap_ram_arb_pick u_rd_pick (
`ifdef ZAP_RAM_ARB_RR_EN
    .clk    (i_clk),
    .reset  (i_reset),
`endif
    .enable (advance),
    .req    (rd_req),
    .grant  (rd_grant)
  );

  assign o_req0_ready = wr_grant[0] | rd_grant[0];
  assign o_req1_ready = wr_grant[1] | rd_grant[1];

  // Steer the winning write and read onto the RAM ports
  always_comb begin
    o_ram_wr_en   = |wr_grant;
    o_ram_wr_addr = wr_grant[1] ? i_req1_addr  : i_req0_addr;
    o_ram_wr_data = wr_grant[1] ? i_req1_wdata : i_req0_wdata;
    o_ram_rd_addr = rd_grant[1] ? i_req1_addr  : i_req0_addr;
  end

  // Tags move in lock-step with the RAM read pipeline, holding when it is stalled
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ZAP_RAM_ARB_RD_LAT; i++) tag_pipe[i] <= '0;
    end else if (o_ram_clken) begin
      tag_pipe[0] <= '{valid: |rd_grant, port: rd_grant[1]};
      for (int i = 1; i < ZAP_RAM_ARB_RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign o_rsp0_valid = tag_out.valid & ~tag_out.port & ~i_reset;
  assign o_rsp1_valid = tag_out.valid &  tag_out.port & ~i_reset;
  assign o_rsp0_data  = i_ram_rd_data;
  assign o_rsp1_data  = i_ram_rd_data;

endmodule

// File: tb/tb_zap_ram_arbiter.sv
// Scoreboard testbench for zap_ram_arbiter with a behavioural 3-cycle RAM.
// Build with ZAP_RAM_ARB_RR_EN defined to check round-robin contention.
module tb_zap_ram_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic             port;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             req0_valid, req0_wr, req0_ready;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_wdata;
  logic             req1_valid, req1_wr, req1_ready;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_wdata;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic             ram_clken, ram_wr_en;
  logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
  logic [WIDTH-1:0] ram_wr_data, ram_rd_data;

  logic [WIDTH-1:0] mem    [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [WIDTH-1:0] ram_s1, ram_s2, ram_s3;
  exp_t             exp_q [$];
  exp_t             mon_e;
  logic             acc0_seen = 1'b0;
  logic             acc1_seen = 1'b0;
  int               n_checks = 0;
  int               n_fail   = 0;

  zap_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_req0_valid  (req0_valid),
    .i_req0_wr     (req0_wr),
    .i_req0_addr   (req0_addr),
    .i_req0_wdata  (req0_wdata),
    .o_req0_ready  (req0_ready),
    .i_req1_valid  (req1_valid),
    .i_req1_wr     (req1_wr),
    .i_req1_addr   (req1_addr),
    .i_req1_wdata  (req1_wdata),
    .o_req1_ready  (req1_ready),
    .o_rsp0_valid  (rsp0_valid),
    .o_rsp0_data   (rsp0_data),
    .i_rsp0_ready  (rsp0_ready),
    .o_rsp1_valid  (rsp1_valid),
    .o_rsp1_data   (rsp1_data),
    .i_rsp1_ready  (rsp1_ready),
    .o_ram_clken   (ram_clken),
    .o_ram_wr_en   (ram_wr_en),
    .o_ram_wr_addr (ram_wr_addr),
    .o_ram_wr_data (ram_wr_data),
    .o_ram_rd_addr (ram_rd_addr),
    .i_ram_rd_data (ram_rd_data)
  );

  // RAM model: 3 registered read stages, write-to-read forwarding, all gated by clken
  always @(posedge clk) begin
    if (ram_clken) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      ram_s1 <= (ram_wr_en && ram_wr_addr == ram_rd_addr) ? ram_wr_data : mem[ram_rd_addr];
      ram_s2 <= ram_s1;
      ram_s3 <= ram_s2;
    end
  end
  assign ram_rd_data = ram_s3;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic noteFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Value a read of addr must return, including a same-cycle write to addr
  function automatic logic [WIDTH-1:0] expectRead(input logic [AW-1:0] addr);
    if (req0_valid && req0_ready && req0_wr && req0_addr == addr) return req0_wdata;
    if (req1_valid && req1_ready && req1_wr && req1_addr == addr) return req1_wdata;
    return shadow[addr];
  endfunction

  // Record accepted requests: update the shadow memory and queue read expectations
  always @(negedge clk) begin
    acc0_seen <= req0_valid & req0_ready;
    acc1_seen <= req1_valid & req1_ready;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (req0_valid && req0_ready && !req0_wr) exp_q.push_back('{port: 1'b0, data: expectRead(req0_addr)});
      if (req1_valid && req1_ready && !req1_wr) exp_q.push_back('{port: 1'b1, data: expectRead(req1_addr)});
      if (req0_valid && req0_ready && req0_wr) shadow[req0_addr] <= req0_wdata;
      if (req1_valid && req1_ready && req1_wr) shadow[req1_addr] <= req1_wdata;
    end
  end

  // Pop and compare each response as it transfers
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid && rsp1_valid) noteFail("rsp_both_valid");
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q.size() == 0) noteFail("rsp0_unexpected");
        else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_order_port0", 64'(1'b0), 64'(mon_e.port));
          checkOutput("rsp0_data", 64'(rsp0_data), 64'(mon_e.data));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q.size() == 0) noteFail("rsp1_unexpected");
        else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_order_port1", 64'(1'b1), 64'(mon_e.port));
          checkOutput("rsp1_data", 64'(rsp1_data), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic applyStimulus(input int port, input logic wr, input logic [AW-1:0] addr,
                               input logic [WIDTH-1:0] data);
    if (port == 0) begin
      req0_valid = 1'b1; req0_wr = wr; req0_addr = addr; req0_wdata = data;
    end else begin
      req1_valid = 1'b1; req1_wr = wr; req1_addr = addr; req1_wdata = data;
    end
  endtask

  task automatic waitAccept(input logic [1:0] mask);
    logic [1:0] pend;
    logic [1:0] got;
    pend = mask;
    for (int i = 0; i < 40 && pend != 2'b00; i++) begin
      @(posedge clk);
      got = {acc1_seen, acc0_seen} & pend;
      #1;
      if (got[0]) req0_valid = 1'b0;
      if (got[1]) req1_valid = 1'b0;
      pend = pend & ~got;
    end
    if (pend != 2'b00) begin
      noteFail("accept_timeout");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic waitRsp(input int port, input logic [WIDTH-1:0] data, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (port == 0 && rsp0_valid) begin checkOutput(name, 64'(rsp0_data), 64'(data)); return; end
      if (port == 1 && rsp1_valid) begin checkOutput(name, 64'(rsp1_data), 64'(data)); return; end
    end
    noteFail({name, "_timeout"});
  endtask

  task automatic syncDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (8) @(negedge clk);
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int got;
    reset = 1'b1;
    req0_valid = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_wr = 1'b0; req1_addr = '0; req1_wdata = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 5'd1, 32'h5);
    @(negedge clk);
    checkOutput("reset_req0_ready", 64'(req0_ready), 64'd0);
    checkOutput("reset_wr_en",      64'(ram_wr_en),  64'd0);
    checkOutput("reset_clken",      64'(ram_clken),  64'd1);
    checkOutput("reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
    checkOutput("reset_rsp1_valid", 64'(rsp1_valid), 64'd0);
    syncDrive();
    req0_valid = 1'b0;
    reset = 1'b0;

    $display("[TB] basic write then read");
    applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
    waitAccept(2'b01);
    applyStimulus(0, 1'b0, 5'd5, '0);
    waitAccept(2'b01);
    @(negedge clk);
    checkOutput("lat_edge1_rsp0", 64'(rsp0_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_edge2_rsp0", 64'(rsp0_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_edge3_rsp0", 64'(rsp0_valid), 64'd1);
    checkOutput("basic_rsp0_data", 64'(rsp0_data), 64'hDEADBEEF);
    checkOutput("basic_rsp1_idle", 64'(rsp1_valid), 64'd0);

    $display("[TB] concurrent write and read");
    syncDrive();
    applyStimulus(0, 1'b1, 5'd3, 32'h11);
    applyStimulus(1, 1'b0, 5'd3, '0);
    @(negedge clk);
    checkOutput("conc_req0_ready", 64'(req0_ready), 64'd1);
    checkOutput("conc_req1_ready", 64'(req1_ready), 64'd1);
    waitAccept(2'b11);
    waitRsp(1, 32'h11, "conc_rsp1_data");

    $display("[TB] read contention");
    syncDrive();
    applyStimulus(0, 1'b0, 5'd5, '0);
    applyStimulus(1, 1'b0, 5'd3, '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef ZAP_RAM_ARB_RR_EN
      checkOutput($sformatf("rr_grant%0d_port0", k), 64'(req0_ready), 64'(k % 2 == 0));
      checkOutput($sformatf("rr_grant%0d_port1", k), 64'(req1_ready), 64'(k % 2 == 1));
`else
      checkOutput($sformatf("fix_grant%0d_port0", k), 64'(req0_ready), 64'd1);
      checkOutput($sformatf("fix_grant%0d_port1", k), 64'(req1_ready), 64'd0);
`endif
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    if (acc1_seen) req1_valid = 1'b0;
    else waitAccept(2'b10);
    drain("contention_drain");

    $display("[TB] response backpressure");
    syncDrive();
    rsp1_ready = 1'b0;
    applyStimulus(1, 1'b0, 5'd3, '0);
    waitAccept(2'b10);
    applyStimulus(0, 1'b0, 5'd5, '0);
    waitAccept(2'b01);
    applyStimulus(0, 1'b0, 5'd5, '0);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (rsp1_valid) got = 1;
    end
    if (got == 0) noteFail("bp_rsp1_timeout");
    applyStimulus(1, 1'b1, 5'd9, 32'h99);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("bp_clken",      64'(ram_clken),  64'd0);
      checkOutput("bp_req0_ready", 64'(req0_ready), 64'd0);
      checkOutput("bp_req1_ready", 64'(req1_ready), 64'd0);
      checkOutput("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
      checkOutput("bp_rsp1_data",  64'(rsp1_data),  64'h11);
    end
    syncDrive();
    rsp1_ready = 1'b1;
    waitAccept(2'b11);
    drain("bp_drain");

    $display("[TB] reset mid-flight");
    syncDrive();
    applyStimulus(0, 1'b1, 5'd7, 32'hCAFEF00D);
    waitAccept(2'b01);
    applyStimulus(0, 1'b0, 5'd7, '0);
    got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      @(posedge clk);
      if (acc0_seen) got++;
    end
    checkOutput("mid_reads_issued", 64'(got), 64'd3);
    #1;
    reset = 1'b1;
    req0_valid = 1'b0;
    applyStimulus(1, 1'b0, 5'd7, '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_reset_clken",      64'(ram_clken),  64'd1);
    checkOutput("mid_reset_req1_ready", 64'(req1_ready), 64'd0);
    checkOutput("mid_reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
    syncDrive();
    reset = 1'b0;
    waitAccept(2'b10);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("post_reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
      checkOutput("post_reset_rsp1_valid", 64'(rsp1_valid), 64'd0);
    end
    waitRsp(1, 32'hCAFEF00D, "post_reset_rsp1_data");
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
